// File: rtl/sync_rw_memory_if.sv
// Bus interface for sync_rw_memory: address, read/write requests, write data,
// and the registered read data / read-valid / conflict-error responses.
interface sync_rw_memory_if #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8
);

  logic [ADDR_WIDTH-1:0] addr;
  logic                  wr_en;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] wdata;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  err;

  // Requester side (bench or upstream logic).
  modport master (
    output addr,
    output wr_en,
    output rd_en,
    output wdata,
    input  rdata,
    input  rvalid,
    input  err
  );

  // Memory side.
  modport slave (
    input  addr,
    input  wr_en,
    input  rd_en,
    input  wdata,
    output rdata,
    output rvalid,
    output err
  );

endinterface

// File: rtl/sync_rw_memory.sv
// Single-port synchronous RAM with registered read data, one-cycle read-valid
// strobe and a one-cycle error flag for simultaneous read/write requests.
// A conflicting request performs neither operation.
// Optional: define MEM_RESET_CLEAR_EN to zero every array word during reset;
// otherwise the array is plain RAM whose contents survive reset.
module sync_rw_memory #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned DATA_WIDTH = 8
) (
  input logic               clk,
  input logic               reset,
  sync_rw_memory_if.slave   bus
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [Depth];

  logic [DATA_WIDTH-1:0] rdata_d, rdata_q;
  logic                  rvalid_d, rvalid_q;
  logic                  err_d, err_q;
  logic                  mem_we;

  // Decode the request: write, read, conflict or idle. Reset drops any request.
  always_comb begin
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    mem_we   = 1'b0;
    if (bus.wr_en && bus.rd_en) begin
      err_d = 1'b1;
    end else if (bus.wr_en) begin
      mem_we = reset;
    end else if (bus.rd_en) begin
      rdata_d  = mem_q[bus.addr];
      rvalid_d = 1'b1;
    end
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

`ifdef MEM_RESET_CLEAR_EN
  // Storage array, cleared to zero while reset is asserted.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else if (mem_we) begin
      mem_q[bus.addr] <= bus.wdata;
    end
  end
`else
  // Storage array without reset so it can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[bus.addr] <= bus.wdata;
    end
  end
`endif

  assign bus.rdata  = rdata_q;
  assign bus.rvalid = rvalid_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sync_rw_memory.sv
// Self-checking bench for sync_rw_memory: a table of directed vectors followed
// by randomized traffic checked against a simple array-based reference model.
module tb_sync_rw_memory;

`ifdef MEM_RESET_CLEAR_EN
  localparam bit Clr = 1'b1;
`else
  localparam bit Clr = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;

  sync_rw_memory_if #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) bus_if ();

  sync_rw_memory #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: memory contents plus which words hold defined data.
  logic [7:0] m_mem [4];
  bit         m_known [4];
  logic [7:0] m_rdata;
  bit         m_rdata_known;
  bit         m_rvalid;
  bit         m_err;

  typedef struct {
    bit         rst_n;
    bit         wr;
    bit         rd;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    bit         exp_rvalid;
    bit         exp_err;
    bit         chk_rdata;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Apply one cycle of inputs, advance the model by the same rules, sample after the edge.
  task automatic step(input bit rst_n, input bit wr, input bit rd, input logic [1:0] a,
                      input logic [7:0] d);
    @(negedge clk);
    reset         = rst_n;
    bus_if.wr_en  = wr;
    bus_if.rd_en  = rd;
    bus_if.addr   = a;
    bus_if.wdata  = d;
    if (!rst_n) begin
      m_rdata       = 8'h00;
      m_rdata_known = 1'b1;
      m_rvalid      = 1'b0;
      m_err         = 1'b0;
      if (Clr) begin
        for (int i = 0; i < 4; i++) begin
          m_mem[i]   = 8'h00;
          m_known[i] = 1'b1;
        end
      end
    end else if (wr && rd) begin
      m_rvalid = 1'b0;
      m_err    = 1'b1;
    end else if (wr) begin
      m_mem[a]   = d;
      m_known[a] = 1'b1;
      m_rvalid   = 1'b0;
      m_err      = 1'b0;
    end else if (rd) begin
      m_rdata       = m_mem[a];
      m_rdata_known = m_known[a];
      m_rvalid      = 1'b1;
      m_err         = 1'b0;
    end else begin
      m_rvalid = 1'b0;
      m_err    = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(bit rst_n, bit wr, bit rd, logic [1:0] a, logic [7:0] d,
                              logic [7:0] er, bit ev, bit ee, bit cr);
    vec_t v;
    v.rst_n = rst_n; v.wr = wr; v.rd = rd; v.addr = a; v.wdata = d;
    v.exp_rdata = er; v.exp_rvalid = ev; v.exp_err = ee; v.chk_rdata = cr;
    return v;
  endfunction

  initial begin
    reset         = 1'b1;
    bus_if.wr_en  = 1'b0;
    bus_if.rd_en  = 1'b0;
    bus_if.addr   = '0;
    bus_if.wdata  = '0;
    m_rdata_known = 1'b0;
    m_rvalid      = 1'b0;
    m_err         = 1'b0;
    m_rdata       = 8'h00;
    for (int i = 0; i < 4; i++) begin
      m_mem[i]   = 8'h00;
      m_known[i] = 1'b0;
    end

    //               rst wr rd addr wdata  rdata  rv err chk
    vecs.push_back(mk(0, 0, 0, 2'd0, 8'h00, 8'h00, 0, 0, 1));  // reset
    vecs.push_back(mk(1, 0, 1, 2'd0, 8'h00, 8'h00, 1, 0, Clr));
    vecs.push_back(mk(1, 0, 1, 2'd1, 8'h00, 8'h00, 1, 0, Clr));
    vecs.push_back(mk(1, 0, 1, 2'd2, 8'h00, 8'h00, 1, 0, Clr));
    vecs.push_back(mk(1, 0, 1, 2'd3, 8'h00, 8'h00, 1, 0, Clr));
    vecs.push_back(mk(1, 1, 0, 2'd0, 8'hA5, 8'h00, 0, 0, Clr));
    vecs.push_back(mk(1, 1, 0, 2'd1, 8'h3C, 8'h00, 0, 0, Clr));
    vecs.push_back(mk(1, 1, 0, 2'd2, 8'hFF, 8'h00, 0, 0, Clr));
    vecs.push_back(mk(1, 1, 0, 2'd3, 8'h01, 8'h00, 0, 0, Clr));
    vecs.push_back(mk(1, 0, 1, 2'd0, 8'h00, 8'hA5, 1, 0, 1));  // back-to-back reads
    vecs.push_back(mk(1, 0, 1, 2'd1, 8'h00, 8'h3C, 1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 2'd2, 8'h00, 8'hFF, 1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 2'd3, 8'h00, 8'h01, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 2'd0, 8'h00, 8'h01, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 2'd2, 8'h11, 8'h01, 0, 0, 1));  // read-after-write
    vecs.push_back(mk(1, 0, 1, 2'd2, 8'h00, 8'h11, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 2'd2, 8'h22, 8'h11, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 2'd2, 8'h00, 8'h22, 1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 2'd0, 8'h00, 8'h22, 0, 0, 1));
    vecs.push_back(mk(1, 0, 0, 2'd3, 8'h9C, 8'h22, 0, 0, 1));
    vecs.push_back(mk(1, 1, 0, 2'd1, 8'h55, 8'h22, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 2'd1, 8'hAA, 8'h22, 0, 1, 1));  // conflict
    vecs.push_back(mk(1, 0, 0, 2'd1, 8'h00, 8'h22, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 2'd1, 8'h00, 8'h55, 1, 0, 1));
    vecs.push_back(mk(1, 1, 0, 2'd3, 8'h77, 8'h55, 0, 0, 1));
    vecs.push_back(mk(0, 0, 1, 2'd3, 8'h00, 8'h00, 0, 0, 1));  // reset drops read
    vecs.push_back(mk(1, 0, 1, 2'd3, 8'h00, Clr ? 8'h00 : 8'h77, 1, 0, 1));
    vecs.push_back(mk(0, 1, 0, 2'd0, 8'hEE, 8'h00, 0, 0, 1));  // reset drops write
    vecs.push_back(mk(1, 0, 1, 2'd0, 8'h00, Clr ? 8'h00 : 8'hA5, 1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 2'd2, 8'h33, Clr ? 8'h00 : 8'hA5, 0, 1, 1));
    vecs.push_back(mk(1, 1, 1, 2'd2, 8'h44, Clr ? 8'h00 : 8'hA5, 0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 2'd2, 8'h00, Clr ? 8'h00 : 8'h22, 1, 0, 1));

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].wdata);
      check($sformatf("vec%0d rvalid", i), 32'(bus_if.rvalid), 32'(vecs[i].exp_rvalid));
      check($sformatf("vec%0d err", i), 32'(bus_if.err), 32'(vecs[i].exp_err));
      if (vecs[i].chk_rdata)
        check($sformatf("vec%0d rdata", i), 32'(bus_if.rdata), 32'(vecs[i].exp_rdata));
    end

    // Randomized traffic against the reference model.
    for (int n = 0; n < 400; n++) begin
      int unsigned op;
      bit          rst_n;
      op    = $urandom_range(0, 9);
      rst_n = ($urandom_range(0, 31) != 0);
      step(rst_n, (op <= 3) || (op == 8), ((op >= 4) && (op <= 7)) || (op == 8),
           2'($urandom_range(0, 3)), 8'($urandom));
      check($sformatf("rnd%0d rvalid", n), 32'(bus_if.rvalid), 32'(m_rvalid));
      check($sformatf("rnd%0d err", n), 32'(bus_if.err), 32'(m_err));
      if (m_rdata_known)
        check($sformatf("rnd%0d rdata", n), 32'(bus_if.rdata), 32'(m_rdata));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
